// File: rtl/riscv_uc.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_uc
//  Purpose  : Multicycle Moore control unit for the RV32 subset datapath.
//             Sequences FETCH/DECODE/execute states, drives every datapath
//             control, traps unsupported opcodes and counts retired
//             instructions.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             opcode, branch        - decode inputs from the datapath
//             pc_load, pc_reset     - PC register controls
//             mem_re, mem_we        - data memory enables
//             reg_file_write        - register file write enable
//             alu_op, select_mux_*  - ALU function and datapath mux selects
//             halted, state         - trap flag and debug state view
//             instret               - retired-instruction counter
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_uc #(
  parameter logic [6:0] OP_R  = 7'b0110011,
  parameter logic [6:0] OP_I  = 7'b0010011,
  parameter logic [6:0] OP_LD = 7'b0000011,
  parameter logic [6:0] OP_ST = 7'b0100011,
  parameter logic [6:0] OP_BR = 7'b1100011,
  parameter int         CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch,
  output logic             pc_load,
  output logic             pc_reset,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_file_write,
  output logic [1:0]       alu_op,
  output logic [1:0]       select_mux_1,
  output logic [1:0]       select_mux_2,
  output logic [1:0]       select_mux_3,
  output logic [1:0]       select_mux_4,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam logic [3:0] S_RST     = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EX_R    = 4'd3;
  localparam logic [3:0] S_WB_R    = 4'd4;
  localparam logic [3:0] S_EX_I    = 4'd5;
  localparam logic [3:0] S_WB_I    = 4'd6;
  localparam logic [3:0] S_LD_ADDR = 4'd7;
  localparam logic [3:0] S_LD_WB   = 4'd8;
  localparam logic [3:0] S_ST      = 4'd9;
  localparam logic [3:0] S_BR_CMP  = 4'd10;
  localparam logic [3:0] S_BR_UPD  = 4'd11;
  localparam logic [3:0] S_TRAP    = 4'd12;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] instret_q;

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RST;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      // pc_load is already forced low under reset, so this is the retire event
      if (pc_load) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_RST;
    case (state_q)
      S_RST:     state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if      (opcode == OP_R)  state_d = S_EX_R;
        else if (opcode == OP_I)  state_d = S_EX_I;
        else if (opcode == OP_LD) state_d = S_LD_ADDR;
        else if (opcode == OP_ST) state_d = S_ST;
        else if (opcode == OP_BR) state_d = S_BR_CMP;
        else                      state_d = S_TRAP;
      end
      S_EX_R:    state_d = S_WB_R;
      S_WB_R:    state_d = S_FETCH;
      S_EX_I:    state_d = S_WB_I;
      S_WB_I:    state_d = S_FETCH;
      S_LD_ADDR: state_d = S_LD_WB;
      S_LD_WB:   state_d = S_FETCH;
      S_ST:      state_d = S_FETCH;
      S_BR_CMP:  state_d = S_BR_UPD;
      S_BR_UPD:  state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_RST;   // encodings 13-15 recover through reset state
    endcase
  end

  // Moore output decode, with reset overriding every write/load enable
  always_comb begin
    pc_load        = 1'b0;
    pc_reset       = 1'b0;
    mem_re         = 1'b0;
    mem_we         = 1'b0;
    reg_file_write = 1'b0;
    alu_op         = 2'b00;
    select_mux_1   = 2'b00;
    select_mux_2   = 2'b00;
    select_mux_3   = 2'b00;
    select_mux_4   = 2'b00;
    halted         = 1'b0;
    case (state_q)
      S_RST:     pc_reset = 1'b1;
      S_EX_R:    alu_op = 2'b10;
      S_WB_R: begin
        alu_op         = 2'b10;
        select_mux_2   = 2'b01;
        reg_file_write = 1'b1;
        pc_load        = 1'b1;
      end
      S_EX_I: begin
        alu_op       = 2'b11;
        select_mux_1 = 2'b01;
      end
      S_WB_I: begin
        alu_op         = 2'b11;
        select_mux_1   = 2'b01;
        select_mux_2   = 2'b01;
        reg_file_write = 1'b1;
        pc_load        = 1'b1;
      end
      S_LD_ADDR: begin
        select_mux_1 = 2'b01;
        mem_re       = 1'b1;
      end
      S_LD_WB: begin
        select_mux_1   = 2'b01;
        mem_re         = 1'b1;
        reg_file_write = 1'b1;
        pc_load        = 1'b1;
      end
      S_ST: begin
        select_mux_1 = 2'b01;
        select_mux_4 = 2'b01;
        mem_we       = 1'b1;
        pc_load      = 1'b1;
      end
      S_BR_CMP:  alu_op = 2'b01;
      S_BR_UPD: begin
        alu_op       = 2'b01;
        pc_load      = 1'b1;
        select_mux_3 = {1'b0, branch};
      end
      S_TRAP:    halted = 1'b1;
      default: ;
    endcase
    if (reset) begin
      pc_load        = 1'b0;
      mem_re         = 1'b0;
      mem_we         = 1'b0;
      reg_file_write = 1'b0;
      pc_reset       = 1'b1;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_uc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_uc
//  Purpose  : Directed self-checking bench for riscv_uc. The counter is
//             built narrow so the wrap from all-ones to zero is reachable.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_uc;

  localparam int         TB_CNT_W = 4;
  localparam logic [6:0] C_OP_R   = 7'b0110011;
  localparam logic [6:0] C_OP_I   = 7'b0010011;
  localparam logic [6:0] C_OP_LD  = 7'b0000011;
  localparam logic [6:0] C_OP_ST  = 7'b0100011;
  localparam logic [6:0] C_OP_BR  = 7'b1100011;

  logic                clk = 1'b0;
  logic                reset;
  logic [6:0]          opcode;
  logic                branch;
  logic                pc_load, pc_reset, mem_re, mem_we, reg_file_write;
  logic [1:0]          alu_op, select_mux_1, select_mux_2, select_mux_3, select_mux_4;
  logic                halted;
  logic [3:0]          state;
  logic [TB_CNT_W-1:0] instret;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_uc #(.CNT_W(TB_CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .branch         (branch),
    .pc_load        (pc_load),
    .pc_reset       (pc_reset),
    .mem_re         (mem_re),
    .mem_we         (mem_we),
    .reg_file_write (reg_file_write),
    .alu_op         (alu_op),
    .select_mux_1   (select_mux_1),
    .select_mux_2   (select_mux_2),
    .select_mux_3   (select_mux_3),
    .select_mux_4   (select_mux_4),
    .halted         (halted),
    .state          (state),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_state(input string tag, input int exp_state);
    step();
    check_eq(tag, {28'b0, state}, exp_state);
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 7'b0;
    branch = 1'b0;

    // ---- reset held two cycles ----
    step();
    step();
    check_eq("rst_state", {28'b0, state}, 0);
    check_eq("rst_instret", {28'b0, instret}, 0);
    check_eq("rst_enables", {28'b0, pc_load, mem_we, reg_file_write, mem_re}, 0);
    check_eq("rst_pc_reset", {31'b0, pc_reset}, 1);
    reset = 1'b0;
    #1;
    check_eq("rel_state0", {28'b0, state}, 0);
    check_eq("rel_pc_reset", {31'b0, pc_reset}, 1);
    step_state("rel_fetch", 1);
    check_eq("fetch_pc_reset", {31'b0, pc_reset}, 0);

    // ---- R-type: 1,2,3,4,1 ----
    opcode = C_OP_R;
    step_state("r_dec", 2);
    step_state("r_ex", 3);
    check_eq("r_ex_ctl", {26'b0, alu_op, select_mux_1, reg_file_write, pc_load}, {26'b0, 2'b10, 2'b00, 1'b0, 1'b0});
    step_state("r_wb", 4);
    check_eq("r_wb_ctl", {22'b0, alu_op, select_mux_2, select_mux_3, reg_file_write, pc_load, mem_we, mem_re},
             {22'b0, 2'b10, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0});
    step_state("r_fetch", 1);
    check_eq("r_instret", {28'b0, instret}, 1);

    // ---- load: 1,2,7,8,1 ----
    opcode = C_OP_LD;
    step_state("ld_dec", 2);
    step_state("ld_addr", 7);
    check_eq("ld_addr_ctl", {26'b0, alu_op, select_mux_1, mem_re, reg_file_write}, {26'b0, 2'b00, 2'b01, 1'b1, 1'b0});
    step_state("ld_wb", 8);
    check_eq("ld_wb_ctl", {24'b0, select_mux_2, select_mux_3, mem_re, reg_file_write, pc_load, mem_we},
             {24'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0});
    step_state("ld_fetch", 1);
    check_eq("ld_instret", {28'b0, instret}, 2);

    // ---- store: 1,2,9,1 ----
    opcode = C_OP_ST;
    step_state("st_dec", 2);
    step_state("st", 9);
    check_eq("st_ctl", {24'b0, select_mux_1, select_mux_4, mem_we, reg_file_write, pc_load, mem_re},
             {24'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0});
    step_state("st_fetch", 1);
    check_eq("st_instret", {28'b0, instret}, 3);

    // ---- I-type: 1,2,5,6,1 ----
    opcode = C_OP_I;
    step_state("i_dec", 2);
    step_state("i_ex", 5);
    check_eq("i_ex_ctl", {28'b0, alu_op, select_mux_1}, {28'b0, 2'b11, 2'b01});
    step_state("i_wb", 6);
    check_eq("i_wb_ctl", {24'b0, alu_op, select_mux_1, select_mux_2, reg_file_write, pc_load},
             {24'b0, 2'b11, 2'b01, 2'b01, 1'b1, 1'b1});
    step_state("i_fetch", 1);
    check_eq("i_instret", {28'b0, instret}, 4);

    // ---- branch taken / not taken ----
    for (int b = 1; b >= 0; b--) begin
      opcode = C_OP_BR;
      branch = b[0];
      step_state("br_dec", 2);
      step_state("br_cmp", 10);
      check_eq("br_cmp_ctl", {27'b0, alu_op, select_mux_1, pc_load}, {27'b0, 2'b01, 2'b00, 1'b0});
      step_state("br_upd", 11);
      check_eq("br_upd_ctl", {27'b0, alu_op, select_mux_3, pc_load}, {27'b0, 2'b01, 1'b0, b[0], 1'b1});
      step_state("br_fetch", 1);
      check_eq("br_instret", {28'b0, instret}, (b == 1) ? 5 : 6);
    end
    branch = 1'b0;

    // ---- unsupported opcode traps ----
    opcode = 7'b1111111;
    step_state("trap_dec", 2);
    step_state("trap", 12);
    for (int i = 0; i < 10; i++) begin
      check_eq("trap_hold", {26'b0, state, halted, pc_load, mem_we, mem_re, reg_file_write, pc_reset},
               {26'b0, 4'd12, 1'b1, 5'b0});
      step();
    end
    check_eq("trap_instret", {28'b0, instret}, 6);
    reset = 1'b1;
    #1;
    check_eq("trap_rst_comb", {30'b0, pc_reset, pc_load}, {30'b0, 1'b1, 1'b0});
    step_state("trap_rst", 0);
    check_eq("trap_rst_halt", {31'b0, halted}, 0);
    check_eq("trap_rst_instret", {28'b0, instret}, 0);
    reset = 1'b0;
    step_state("trap_rel_fetch", 1);

    // ---- reset asserted in the store state ----
    opcode = C_OP_ST;
    step_state("st2_dec", 2);
    step_state("st2", 9);
    check_eq("st2_we_pre", {31'b0, mem_we}, 1);
    reset = 1'b1;
    #1;
    check_eq("st2_rst_comb", {28'b0, mem_we, pc_load, reg_file_write, pc_reset}, {28'b0, 4'b0001});
    step_state("st2_rst", 0);
    check_eq("st2_rst_instret", {28'b0, instret}, 0);
    reset = 1'b0;
    step_state("st2_rel_fetch", 1);

    // ---- counter wrap: all-ones, then one more retire ----
    for (int i = 0; i < (1 << TB_CNT_W) - 1; i++) begin
      step();
      step();
      step();
    end
    check_eq("wrap_state", {28'b0, state}, 1);
    check_eq("wrap_full", {28'b0, instret}, 32'hF);
    step_state("wrap_dec", 2);
    step_state("wrap_st", 9);
    step_state("wrap_fetch", 1);
    check_eq("wrap_zero", {28'b0, instret}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
